// File: rtl/spi_ahb_loader.sv
// Boot loader: an SPI mode-0 byte stream becomes single-beat 32-bit AHB-Lite writes.
// A frame addressed to DONE_ADDR hands the bus to the core through a one-clock spi_change pulse.
module spi_ahb_loader #(
  parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
  parameter logic [15:0] DONE_ADDR = 16'hFFFF,
  parameter int unsigned SYNC_STG  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        cs_n,
  input  logic        hready,
  input  logic        hresp,
  input  logic [31:0] hrdata,
  output logic [31:0] haddr,
  output logic        hwrite,
  output logic [2:0]  hsize,
  output logic [2:0]  hburst,
  output logic        hmastlock,
  output logic [3:0]  hprot,
  output logic [1:0]  htrans,
  output logic [31:0] hwdata,
  output logic        spi_change,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {ST_IDLE, ST_ADDR, ST_DATA} state_e;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  logic [SYNC_STG-1:0] sclk_sync_q, mosi_sync_q, cs_sync_q;
  logic                sclk_prev_q, cs_prev_q;
  logic                sclk_s, mosi_s, cs_s, sclk_rise, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STG-1];
  assign mosi_s    = mosi_sync_q[SYNC_STG-1];
  assign cs_s      = cs_sync_q[SYNC_STG-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sclk_sync_q <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      sclk_sync_q <= {sclk_sync_q[SYNC_STG-2:0], sclk};
      mosi_sync_q <= {mosi_sync_q[SYNC_STG-2:0], mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STG-2:0], cs_n};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
    end
  end

  logic [2:0]  bit_cnt_q;
  logic [6:0]  shift_q;
  logic [1:0]  hdr_cnt_q;   // 0/1: address bytes pending, 2: header complete
  logic [1:0]  wb_cnt_q;
  logic [7:0]  addr_hi_q;
  logic [15:0] ptr_q;
  logic [23:0] word_sr_q;
  logic        done_frame_q;
  logic        word_done_q;
  logic [15:0] word_ptr_q;
  logic [31:0] word_q;
  logic [7:0]  rx_byte;

  assign rx_byte = {shift_q, mosi_s};

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      hdr_cnt_q    <= '0;
      wb_cnt_q     <= '0;
      addr_hi_q    <= '0;
      ptr_q        <= '0;
      word_sr_q    <= '0;
      done_frame_q <= 1'b0;
      word_done_q  <= 1'b0;
      word_ptr_q   <= '0;
      word_q       <= '0;
    end else begin
      word_done_q <= 1'b0;
      if (cs_rise) begin
        bit_cnt_q    <= '0;
        hdr_cnt_q    <= '0;
        wb_cnt_q     <= '0;
        done_frame_q <= 1'b0;
      end else if (sclk_rise && !cs_s) begin
        shift_q   <= rx_byte[6:0];
        bit_cnt_q <= bit_cnt_q + 3'd1;
        if (bit_cnt_q == 3'd7) begin
          unique case (hdr_cnt_q)
            2'd0: begin
              addr_hi_q <= rx_byte;
              hdr_cnt_q <= 2'd1;
            end
            2'd1: begin
              ptr_q        <= {addr_hi_q, rx_byte};
              done_frame_q <= ({addr_hi_q, rx_byte} == DONE_ADDR);
              hdr_cnt_q    <= 2'd2;
            end
            default: begin
              if (!done_frame_q) begin
                word_sr_q <= {word_sr_q[15:0], rx_byte};
                wb_cnt_q  <= wb_cnt_q + 2'd1;
                if (wb_cnt_q == 2'd3) begin
                  word_done_q <= 1'b1;
                  word_q      <= {word_sr_q, rx_byte};
                  word_ptr_q  <= ptr_q;
                  ptr_q       <= ptr_q + 16'd4;
                end
              end
            end
          endcase
        end
      end
    end
  end

  state_e      state_q, state_d;
  logic [31:0] haddr_q, haddr_d, hwdata_q, hwdata_d;
  logic        hwrite_q, hwrite_d;
  logic [1:0]  htrans_q, htrans_d;
  logic        pend_valid_q;
  logic [15:0] pend_ptr_q;
  logic [31:0] pend_word_q;
  logic        err_q, done_q, spi_change_q;
  logic        pend_clr, pend_load, overflow, err_set, change_fire;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    htrans_d = htrans_q;
    hwdata_d = hwdata_q;
    pend_clr = 1'b0;
    err_set  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pend_valid_q) begin
          state_d  = ST_ADDR;
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
          haddr_d  = ADDR_BASE + {16'h0000, pend_ptr_q};
        end
      end
      ST_ADDR: begin
        if (hready) begin
          state_d  = ST_DATA;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
          hwdata_d = pend_word_q;
          pend_clr = 1'b1;
        end
      end
      ST_DATA: begin
        err_set = hresp;
        if (hready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // A slot freed by this cycle's address acceptance can take the new word.
    pend_load   = word_done_q & (~pend_valid_q | pend_clr);
    overflow    = word_done_q & pend_valid_q & ~pend_clr;
    change_fire = done_q & (state_q == ST_IDLE) & ~pend_valid_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      haddr_q      <= '0;
      hwrite_q     <= 1'b0;
      htrans_q     <= HTRANS_IDLE;
      hwdata_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_ptr_q   <= '0;
      pend_word_q  <= '0;
      err_q        <= 1'b0;
      done_q       <= 1'b0;
      spi_change_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      htrans_q <= htrans_d;
      hwdata_q <= hwdata_d;
      if (pend_load) begin
        pend_valid_q <= 1'b1;
        pend_ptr_q   <= word_ptr_q;
        pend_word_q  <= word_q;
      end else if (pend_clr) begin
        pend_valid_q <= 1'b0;
      end
      err_q        <= err_q | err_set | overflow;
      spi_change_q <= change_fire;
      if (change_fire) done_q <= 1'b0;
      if (cs_rise && hdr_cnt_q == 2'd2 && done_frame_q) done_q <= 1'b1;
    end
  end

  logic unused_hrdata;
  assign unused_hrdata = ^hrdata;

  assign haddr      = haddr_q;
  assign hwrite     = hwrite_q;
  assign htrans     = htrans_q;
  assign hwdata     = hwdata_q;
  assign hsize      = 3'b010;
  assign hburst     = 3'b000;
  assign hmastlock  = 1'b0;
  assign hprot      = 4'b0011;
  assign spi_change = spi_change_q;
  assign err        = err_q;
  assign busy       = ~cs_s | pend_valid_q | (state_q != ST_IDLE) | done_q;

endmodule

// File: tb/tb_spi_ahb_loader.sv
// Bench for spi_ahb_loader: SPI host driver, responsive AHB slave monitor, and a frame-level
// reference model that turns each sent frame into the list of writes it must produce.
module tb_spi_ahb_loader;

  localparam int          SCLK_HALF = 40;
  localparam logic [31:0] ADDR_BASE = 32'h0000_0000;
  localparam logic [15:0] DONE_ADDR = 16'hFFFF;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } xfer_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1;
  logic        hready, hresp;
  logic [31:0] hrdata;
  logic [31:0] haddr, hwdata;
  logic        hwrite, hmastlock, spi_change, busy, err;
  logic [2:0]  hsize, hburst;
  logic [3:0]  hprot;
  logic [1:0]  htrans;

  assign hrdata = 32'h0;

  spi_ahb_loader #(.ADDR_BASE(ADDR_BASE), .DONE_ADDR(DONE_ADDR), .SYNC_STG(2)) dut (
    .clk(clk), .reset(reset), .sclk(sclk), .mosi(mosi), .cs_n(cs_n),
    .hready(hready), .hresp(hresp), .hrdata(hrdata), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot), .htrans(htrans),
    .hwdata(hwdata), .spi_change(spi_change), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int          tests = 0, fails = 0;
  xfer_t       exp_q[$];
  xfer_t       obs_q[$];
  logic [7:0]  frame_q[$];

  // Slave behaviour knobs, written only by the stimulus process.
  int          cfg_addr_wait = 0, cfg_data_wait = 0;
  bit          cfg_rand = 1'b0;
  logic [31:0] cfg_err_addr = 32'hFFFF_FFFF;

  // Monitor state, written only by the slave process.
  bit          dphase = 1'b0, aseen = 1'b0, err_now = 1'b0;
  int          await_n = 0, dwait_n = 0, stall_cnt = 0, last_stall = 0;
  int          addr_moved = 0, proto_err = 0, chg_cnt = 0, chg_obs = 0, chg_bad = 0;
  logic [31:0] cur_addr = '0, first_addr = '0;

  // Slave: decide hready/hresp for the coming edge, then record what that edge completes.
  always @(negedge clk) begin
    if (reset) begin
      dphase = 1'b0; aseen = 1'b0; hready = 1'b1; hresp = 1'b0;
    end else begin
      if (dphase) begin
        if (dwait_n > 0) begin hready = 1'b0; dwait_n--; end
        else hready = 1'b1;
        hresp = err_now;
        if (htrans !== 2'b00 || hwrite !== 1'b0) proto_err++;
      end else if (htrans === 2'b10) begin
        hresp = 1'b0;
        if (!aseen) begin
          aseen = 1'b1; first_addr = haddr; stall_cnt = 0;
          await_n = cfg_rand ? int'($urandom_range(0, 3)) : cfg_addr_wait;
        end else if (haddr !== first_addr) addr_moved++;
        if (hwrite !== 1'b1) proto_err++;
        if (await_n > 0) begin hready = 1'b0; await_n--; stall_cnt++; end
        else hready = 1'b1;
      end else begin
        hready = 1'b1; hresp = 1'b0;
        if (aseen) addr_moved++;
      end
      if (dphase && hready) begin
        obs_q.push_back({cur_addr, hwdata});
        dphase = 1'b0;
      end else if (!dphase && htrans === 2'b10 && hready) begin
        cur_addr = haddr; dphase = 1'b1; aseen = 1'b0; last_stall = stall_cnt;
        err_now = (haddr == cfg_err_addr);
        dwait_n = cfg_rand ? int'($urandom_range(0, 3)) : cfg_data_wait;
        if (err_now && dwait_n == 0) dwait_n = 1;
      end
      if (spi_change === 1'b1) begin
        chg_cnt++; chg_obs = obs_q.size();
        if (htrans !== 2'b00 || dphase) chg_bad++;
      end
    end
  end

  // Reference model: header gives a 16-bit word pointer, each complete group of four bytes is
  // one big-endian word, partial trailing data is lost, DONE_ADDR frames write nothing.
  function automatic void model_frame();
    logic [15:0] ptr;
    xfer_t       x;
    if (frame_q.size() < 2) return;
    ptr = {frame_q[0], frame_q[1]};
    if (ptr == DONE_ADDR) return;
    for (int w = 0; w < (frame_q.size() - 2) / 4; w++) begin
      x.addr = ADDR_BASE + {16'h0000, ptr};
      x.data = {frame_q[2+4*w], frame_q[3+4*w], frame_q[4+4*w], frame_q[5+4*w]};
      exp_q.push_back(x);
      ptr = ptr + 16'd4;
    end
  endfunction

  task automatic spi_bits(input logic [7:0] b, input int n);
    for (int i = 7; i > 7 - n; i--) begin
      mosi = b[i];
      #SCLK_HALF sclk = 1'b1;
      #SCLK_HALF sclk = 1'b0;
    end
  endtask

  task automatic send_frame(input int tail_bits);
    @(negedge clk);
    #2 cs_n = 1'b0;
    #SCLK_HALF;
    foreach (frame_q[i]) spi_bits(frame_q[i], 8);
    if (tail_bits > 0) spi_bits(8'hA5, tail_bits);
    #SCLK_HALF cs_n = 1'b1;
    model_frame();
    #(2 * SCLK_HALF);
  endtask

  task automatic add_words(input int n);
    for (int i = 0; i < 4 * n; i++) frame_q.push_back(8'($urandom));
  endtask

  task automatic wait_for_xfers(input int budget);
    int c = 0;
    while (obs_q.size() < exp_q.size() && c < budget) begin @(negedge clk); c++; end
    repeat (4) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({haddr, hwrite, htrans, hwdata, spi_change, busy, err} !== 70'h0) begin
      fails++;
      $display("FAIL reset_state: haddr=%h hwrite=%b htrans=%b hwdata=%h chg=%b busy=%b err=%b, required all zero",
               haddr, hwrite, htrans, hwdata, spi_change, busy, err);
    end
    tests++;
    if ({hsize, hburst, hmastlock, hprot} !== {3'b010, 3'b000, 1'b0, 4'b0011}) begin
      fails++;
      $display("FAIL const_ctrl: hsize=%b hburst=%b hmastlock=%b hprot=%b, required 010 000 0 0011",
               hsize, hburst, hmastlock, hprot);
    end
    #1 reset = 1'b0;
  endtask

  task automatic test_basic();
    int base = exp_q.size();
    frame_q = '{8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_frame(0);
    wait_for_xfers(500);
    tests++;
    if (obs_q.size() != base + 1 || obs_q[base] !== {32'h10, 32'hDEADBEEF}) begin
      fails++;
      $display("FAIL basic_write: got %0d transfers, last %h, required 1 transfer 00000010deadbeef",
               obs_q.size() - base, obs_q.size() > 0 ? obs_q[obs_q.size()-1] : 64'h0);
    end
    tests++;
    if (hsize !== 3'b010 || err !== 1'b0 || proto_err != 0) begin
      fails++;
      $display("FAIL basic_ctrl: hsize=%b err=%b proto_err=%0d, required 010 0 0", hsize, err, proto_err);
    end
  endtask

  task automatic test_words(input string name, input logic [15:0] start, input int n);
    int base = exp_q.size();
    frame_q = '{start[15:8], start[7:0]};
    add_words(n);
    send_frame(0);
    wait_for_xfers(2000);
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL %s_count: got %0d transfers, required %0d", name, obs_q.size(), exp_q.size());
    end
    for (int i = base; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL %s_xfer%0d: got %h, required %h", name, i - base,
                 i < obs_q.size() ? obs_q[i] : 64'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_addr_stall();
    int moved0 = addr_moved;
    cfg_addr_wait = 5;
    test_words("stall", 16'h0200, 1);
    cfg_addr_wait = 0;
    tests++;
    if (last_stall != 5 || addr_moved != moved0 || proto_err != 0) begin
      fails++;
      $display("FAIL addr_stall: stall=%0d moved=%0d proto_err=%0d, required 5 0 0",
               last_stall, addr_moved - moved0, proto_err);
    end
  endtask

  task automatic test_random();
    int base = exp_q.size();
    logic [15:0] a;
    cfg_rand = 1'b1;
    for (int f = 0; f < 6; f++) begin
      a = 16'($urandom);
      if (a == DONE_ADDR) a = 16'h1234;
      frame_q = '{a[15:8], a[7:0]};
      add_words(int'($urandom_range(1, 3)));
      for (int r = $urandom_range(0, 3); r > 0; r--) frame_q.push_back(8'($urandom));
      send_frame(int'($urandom_range(0, 7)));
      wait_for_xfers(2000);
    end
    cfg_rand = 1'b0;
    tests++;
    if (obs_q.size() != exp_q.size()) begin
      fails++;
      $display("FAIL random_count: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = base; i < exp_q.size(); i++) begin
      tests++;
      if (i >= obs_q.size() || obs_q[i] !== exp_q[i]) begin
        fails++;
        $display("FAIL random_xfer%0d: got %h, required %h", i - base,
                 i < obs_q.size() ? obs_q[i] : 64'h0, exp_q[i]);
      end
    end
  endtask

  task automatic test_partial();
    int n0 = obs_q.size();
    frame_q = '{8'h00, 8'h20, 8'hAA, 8'hBB};
    send_frame(4);
    frame_q = '{8'h12};
    send_frame(0);
    repeat (100) @(negedge clk);
    tests++;
    if (obs_q.size() != n0 || exp_q.size() != n0) begin
      fails++;
      $display("FAIL partial_frame: got %0d transfers, required 0", obs_q.size() - n0);
    end
    test_words("after_partial", 16'h0024, 1);
  endtask

  task automatic test_error();
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL err_before: got %b, required 0", err); end
    cfg_err_addr = 32'h0000_0100;
    test_words("error", 16'h0100, 2);
    cfg_err_addr = 32'hFFFF_FFFF;
    tests++;
    if (err !== 1'b1) begin fails++; $display("FAIL err_set: got %b, required 1", err); end
  endtask

  task automatic test_done();
    int c0 = chg_cnt;
    cfg_addr_wait = 900;
    frame_q = '{8'h00, 8'h30};
    add_words(1);
    send_frame(0);
    frame_q = '{8'hFF, 8'hFF, 8'h11, 8'h22, 8'h33, 8'h44};
    send_frame(0);
    cfg_addr_wait = 0;
    tests++;
    if (chg_cnt != c0 || busy !== 1'b1) begin
      fails++;
      $display("FAIL done_early: pulses=%0d busy=%b, required 0 1", chg_cnt - c0, busy);
    end
    wait_for_xfers(2000);
    repeat (20) @(negedge clk);
    tests++;
    if (chg_cnt - c0 != 1 || chg_bad != 0 || chg_obs != exp_q.size()) begin
      fails++;
      $display("FAIL done_pulse: pulses=%0d bad=%0d xfers_at_pulse=%0d, required 1 0 %0d",
               chg_cnt - c0, chg_bad, chg_obs, exp_q.size());
    end
    tests++;
    if (obs_q.size() != exp_q.size() || obs_q[obs_q.size()-1] !== exp_q[exp_q.size()-1]) begin
      fails++;
      $display("FAIL done_xfer: got %0d transfers, required %0d", obs_q.size(), exp_q.size());
    end
    tests++;
    if (err !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL done_after: err=%b busy=%b, required 1 0", err, busy);
    end
  endtask

  task automatic test_reset_in_data();
    int c = 0;
    int n0 = obs_q.size();
    cfg_data_wait = 60;
    frame_q = '{8'h00, 8'h40};
    add_words(1);
    send_frame(0);
    while (!dphase && c < 2000) begin @(negedge clk); c++; end
    tests++;
    if (!dphase) begin fails++; $display("FAIL reset_data_wait: data phase never reached"); end
    @(negedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    tests++;
    if (htrans !== 2'b00) begin fails++; $display("FAIL reset_htrans: got %b, required 00", htrans); end
    tests++;
    if ({haddr, hwrite, hwdata, spi_change, busy, err} !== 68'h0) begin
      fails++;
      $display("FAIL reset_outputs: haddr=%h hwrite=%b hwdata=%h chg=%b busy=%b err=%b, required all zero",
               haddr, hwrite, hwdata, spi_change, busy, err);
    end
    #1 reset = 1'b0;
    cfg_data_wait = 0;
    void'(exp_q.pop_back());
    repeat (20) @(negedge clk);
    tests++;
    if (obs_q.size() != n0) begin
      fails++;
      $display("FAIL reset_discard: got %0d transfers, required 0", obs_q.size() - n0);
    end
    test_words("after_reset", 16'h0050, 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_words("multi", 16'h4000, 3);
    test_words("wrap", 16'hFFF8, 3);
    test_addr_stall();
    test_random();
    test_partial();
    test_error();
    test_done();
    test_reset_in_data();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
